// File: rtl/lab_pkg.sv
// Shared types and constants for the calculation controller and its result buffer.
package lab_pkg;

    // Occupancy view of the result FIFO.
    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_PARTIAL,
        BUF_FULL
    } buf_state_t;

    // Width of one result word produced by the controller.
    localparam int RESULT_W = 16;

endpackage

// File: rtl/result_buffer_fifo_ptr.sv
// Wrapping FIFO pointer: advances by one on i_inc and wraps DEPTH-1 -> 0.
module fifo_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_inc,
    output logic [$clog2(DEPTH)-1:0] o_ptr
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] r_ptr;

    // Pointer register; explicit wrap keeps intent clear even though DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            if (r_ptr == PW'(DEPTH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr + PW'(1);
            end
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/result_buffer.sv
// Result FIFO between the calculation controller and its consumer.
// Captures a word on every accepted in_valid, presents the oldest word over
// valid/ready, and flags pushes dropped while full.
module result_buffer
    import lab_pkg::*;
#(
    parameter int DATA_W = RESULT_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_next;
    buf_state_t        r_state;
    buf_state_t        w_state_next;
    logic              r_in_ready;
    logic              r_overflow;
    logic [PW-1:0]     w_wr_ptr;
    logic [PW-1:0]     w_rd_ptr;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    // Push is gated by full only, never by a same-cycle pop: no ready-to-ready path.
    assign w_full  = (r_state == BUF_FULL);
    assign w_empty = (r_state == BUF_EMPTY);
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = ~w_empty & out_ready;
    assign w_drop  = in_valid & w_full;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_push),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_pop),
        .o_ptr (w_rd_ptr)
    );

    // Next occupancy and storage state from pre-edge push/pop.
    always_comb begin
        w_count_next = r_count;
        w_state_next = r_state;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
        case (r_state)
            BUF_EMPTY: begin
                if (w_push) w_state_next = BUF_PARTIAL;
            end
            BUF_PARTIAL: begin
                if (w_push && !w_pop && r_count == CW'(DEPTH - 1)) begin
                    w_state_next = BUF_FULL;
                end else if (w_pop && !w_push && r_count == CW'(1)) begin
                    w_state_next = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (w_pop) w_state_next = BUF_PARTIAL;
            end
            default: w_state_next = BUF_EMPTY;
        endcase
    end

    // State, count and registered in_ready (derived from the next state so it tracks count).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BUF_EMPTY;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_in_ready <= (w_state_next != BUF_FULL);
        end
    end

    // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_ptr] <= in_data;
    end

    // Head word is forced to zero while empty so stale/uninitialised storage never shows.
    assign out_data  = w_empty ? '0 : r_mem[w_rd_ptr];
    assign out_valid = ~w_empty;
    assign in_ready  = r_in_ready;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_result_buffer.sv
// Bench for result_buffer: directed vector table, hand sequences, random run vs a queue model.
module tb_result_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic [2:0]        count;
    logic              overflow;
    logic              clr_ovf = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain queue plus sticky flag.
    logic [DATA_W-1:0] m_q[$];
    logic              m_ovf = 1'b0;

    always #5 clk = ~clk;

    result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        r;
        logic        c;
        int          e_cnt;
        logic        e_vld;
        logic [15:0] e_dat;
        logic        e_ovf;
        logic        e_ir;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Compare every DUT output with the queue model.
    task automatic chk_model(input string tag);
        chk({tag, " count"}, 32'(count), 32'(m_q.size()));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(m_q.size() != DEPTH));
        chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) chk({tag, " out_data"}, 32'(out_data), 32'(m_q[0]));
    endtask

    // Drive one cycle, advance the model by the buffer's rules, then compare.
    task automatic step(input logic v, input logic [15:0] d, input logic r, input logic c,
                        input string tag);
        logic full, drop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clr_ovf   = c;
        full = (m_q.size() == DEPTH);
        drop = v && full;
        @(posedge clk);
        #1;
        if (r && m_q.size() != 0) void'(m_q.pop_front());
        if (v && !full) m_q.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        chk_model(tag);
    endtask

    vec_t tbl[15];

    initial begin
        // v, d, r, c | count, valid, data, ovf, in_ready
        tbl[0]  = '{1, 16'h00A5, 0, 0, 1, 1, 16'h00A5, 0, 1};
        tbl[1]  = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1};
        tbl[2]  = '{1, 16'h0001, 0, 0, 1, 1, 16'h0001, 0, 1};
        tbl[3]  = '{1, 16'h0002, 0, 0, 2, 1, 16'h0001, 0, 1};
        tbl[4]  = '{1, 16'h0003, 0, 0, 3, 1, 16'h0001, 0, 1};
        tbl[5]  = '{1, 16'h0004, 0, 0, 4, 1, 16'h0001, 0, 0};
        tbl[6]  = '{1, 16'h0005, 1, 0, 3, 1, 16'h0002, 1, 1};
        tbl[7]  = '{0, 16'h0000, 0, 1, 3, 1, 16'h0002, 0, 1};
        tbl[8]  = '{1, 16'h0006, 0, 0, 4, 1, 16'h0002, 0, 0};
        tbl[9]  = '{1, 16'h0007, 0, 1, 4, 1, 16'h0002, 1, 0};
        tbl[10] = '{0, 16'h0000, 1, 1, 3, 1, 16'h0003, 0, 1};
        tbl[11] = '{0, 16'h0000, 1, 0, 2, 1, 16'h0004, 0, 1};
        tbl[12] = '{0, 16'h0000, 1, 0, 1, 1, 16'h0006, 0, 1};
        tbl[13] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1};
        tbl[14] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1};

        // Reset state
        #12;
        chk("rst count", 32'(count), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst overflow", 32'(overflow), 0);
        chk("rst out_data", 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table: single word, fill, drop on full+pop, clear, set-wins, drain
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d tbl valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d tbl ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d tbl in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            if (tbl[i].e_vld)
                chk($sformatf("vec%0d tbl data", i), 32'(out_data), 32'(tbl[i].e_dat));
        end

        // Streaming at count=2: preload 8,9, then push 10..17 while popping
        step(1, 16'd8, 0, 0, "pre0");
        step(1, 16'd9, 0, 0, "pre1");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream head%0d", i), 32'(out_data), (i < 2) ? 32'(8 + i) : 32'(8 + i));
            step(1, 16'(10 + i), 1, 0, $sformatf("stream%0d", i));
            chk($sformatf("stream count%0d", i), 32'(count), 2);
        end

        // Consumer stall: head must stay put and count unchanged
        for (int i = 0; i < 5; i++) begin
            step(0, 16'hFFFF, 0, 0, $sformatf("stall%0d", i));
            chk($sformatf("stall data%0d", i), 32'(out_data), 32'd16);
            chk($sformatf("stall count%0d", i), 32'(count), 2);
        end

        // Async reset mid-cycle with three words stored
        step(1, 16'h1234, 0, 0, "fill3");
        #2;
        rst = 1'b0;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        chk("async count", 32'(count), 0);
        chk("async out_valid", 32'(out_valid), 0);
        chk("async in_ready", 32'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1, 16'hBEEF, 0, 0, "postrst");
        chk("postrst data", 32'(out_data), 32'h0000BEEF);

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60), 16'($urandom), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 10), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
